// File: rtl/traffic_pkg.sv
// traffic_pkg: definitions shared across the traffic junction controller.
//   state_t       - junction FSM state encoding
//   DEF_T_*       - default phase lengths in clock cycles
//   TIMER_W       - phase timer width (holds any phase length 1..255)
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED,
        RED_AMBER,
        GREEN,
        AMBER,
        WALK,
        FLASH
    } state_t;

    localparam int TIMER_W       = 8;

    localparam int DEF_T_ALL_RED   = 2;
    localparam int DEF_T_RED_AMBER = 2;
    localparam int DEF_T_GREEN     = 4;
    localparam int DEF_T_AMBER     = 2;
    localparam int DEF_T_WALK      = 3;
    localparam int DEF_T_FLASH     = 2;

endpackage

// File: rtl/traffic_junction_phase_timer.sv
// phase_timer: loadable 8-bit down-counter that times one phase.
//   clk      - clock
//   load     - load load_val this cycle (takes priority over counting)
//   load_val - phase length in cycles, 1..255
//   expire   - high during the final cycle of the phase (count == 1)
// The owner reloads on expiry, so the counter never needs to pass below 1.
module phase_timer
    import traffic_pkg::*;
(
    input  logic               clk,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expire
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == TIMER_W'(1));

endmodule

// File: rtl/traffic_junction.sv
// traffic_junction: N-way junction lamp controller with a pedestrian phase
// and a flashing-amber fault/maintenance mode.
//   clk        - clock
//   rst        - synchronous, active-low reset
//   ped_req    - pedestrian request, sampled every cycle
//   flash      - flashing-amber mode request (level)
//   red/amber/green - per-way lamps, registered
//   walk       - pedestrian walk lamp
//   ped_wait   - a pedestrian request is latched and waiting
//   active_way - way currently holding right-of-way
module traffic_junction
    import traffic_pkg::*;
#(
    parameter int N_WAYS      = 2,
    parameter int T_ALL_RED   = DEF_T_ALL_RED,
    parameter int T_RED_AMBER = DEF_T_RED_AMBER,
    parameter int T_GREEN     = DEF_T_GREEN,
    parameter int T_AMBER     = DEF_T_AMBER,
    parameter int T_WALK      = DEF_T_WALK,
    parameter int T_FLASH     = DEF_T_FLASH,
    localparam int AW = (N_WAYS > 2) ? $clog2(N_WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ped_req,
    input  logic              flash,
    output logic [N_WAYS-1:0] red,
    output logic [N_WAYS-1:0] amber,
    output logic [N_WAYS-1:0] green,
    output logic              walk,
    output logic              ped_wait,
    output logic [AW-1:0]     active_way
);

    state_t             state, st_nx;
    logic [AW-1:0]      way, way_nx;
    logic               latch, latch_nx;
    logic               amb, amb_nx;
    logic               ld, expire;
    logic [TIMER_W-1:0] ld_val;
    logic [N_WAYS-1:0]  r_nx, a_nx, g_nx;

    function automatic logic [TIMER_W-1:0] t_of(input state_t s);
        case (s)
            RED_AMBER: t_of = TIMER_W'(T_RED_AMBER);
            GREEN:     t_of = TIMER_W'(T_GREEN);
            AMBER:     t_of = TIMER_W'(T_AMBER);
            WALK:      t_of = TIMER_W'(T_WALK);
            FLASH:     t_of = TIMER_W'(T_FLASH);
            default:   t_of = TIMER_W'(T_ALL_RED);
        endcase
    endfunction

    function automatic logic [AW-1:0] next_way(input logic [AW-1:0] w);
        next_way = (w == AW'(N_WAYS - 1)) ? '0 : w + 1'b1;
    endfunction

    phase_timer u_timer (
        .clk      (clk),
        .load     (ld),
        .load_val (ld_val),
        .expire   (expire)
    );

    // Next-state decode. Reset, then flash, then timer expiry, in priority order.
    always_comb begin
        st_nx    = state;
        way_nx   = way;
        latch_nx = latch;
        amb_nx   = amb;
        ld       = 1'b0;
        if (!rst) begin
            st_nx    = ALL_RED;
            way_nx   = '0;
            latch_nx = 1'b0;
            amb_nx   = 1'b0;
            ld       = 1'b1;
        end else begin
            if (flash) begin
                if (state != FLASH) begin
                    st_nx  = FLASH;
                    amb_nx = 1'b1;
                    ld     = 1'b1;
                end else if (expire) begin
                    amb_nx = ~amb;
                    ld     = 1'b1;
                end
            end else begin
                case (state)
                    ALL_RED:   if (expire) begin st_nx = RED_AMBER; ld = 1'b1; end
                    RED_AMBER: if (expire) begin st_nx = GREEN;     ld = 1'b1; end
                    GREEN:     if (expire) begin st_nx = AMBER;     ld = 1'b1; end
                    AMBER: begin
                        if (expire) begin
                            ld = 1'b1;
                            // Include ped_req so a request in the last amber cycle is served now.
                            if (latch || ped_req) begin
                                st_nx = WALK;
                            end else begin
                                st_nx  = ALL_RED;
                                way_nx = next_way(way);
                            end
                        end
                    end
                    WALK: begin
                        if (expire) begin
                            st_nx  = ALL_RED;
                            way_nx = next_way(way);
                            ld     = 1'b1;
                        end
                    end
                    default: begin
                        // Leaving FLASH restarts the rotation from way 0.
                        st_nx  = ALL_RED;
                        way_nx = '0;
                        ld     = 1'b1;
                    end
                endcase
            end
            if (st_nx == WALK && state != WALK) begin
                latch_nx = 1'b0;
            end else if (ped_req && state != WALK) begin
                latch_nx = 1'b1;
            end
        end
        ld_val = t_of(st_nx);
    end

    // Lamps are decoded from the next state so the registered lamps line up with state.
    always_comb begin
        r_nx = '0;
        a_nx = '0;
        g_nx = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            if (st_nx == FLASH) begin
                a_nx[i] = amb_nx;
            end else if (way_nx == AW'(i)) begin
                case (st_nx)
                    RED_AMBER: begin r_nx[i] = 1'b1; a_nx[i] = 1'b1; end
                    GREEN:     g_nx[i] = 1'b1;
                    AMBER:     a_nx[i] = 1'b1;
                    default:   r_nx[i] = 1'b1;
                endcase
            end else begin
                r_nx[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ALL_RED;
            way   <= '0;
            latch <= 1'b0;
            amb   <= 1'b0;
        end else begin
            state <= st_nx;
            way   <= way_nx;
            latch <= latch_nx;
            amb   <= amb_nx;
        end
        red   <= r_nx;
        amber <= a_nx;
        green <= g_nx;
        walk  <= (st_nx == WALK);
    end

    assign ped_wait   = latch;
    assign active_way = way;

endmodule
